// File: rtl/time_of_day_counter.sv
// time_of_day_counter: hours/minutes/seconds BCD time-of-day counter.
// Counts seconds from a prescaled tick pulse and provides minute/hour set
// pulses. All digit outputs are registered. A one-cycle day_pulse marks the
// midnight rollover.
//
// Optional build macro: FORMAT_12H_EN selects 12-hour counting (12,01..11)
// with a pm flag. When it is undefined, counting is 24-hour and pm is tied 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  seconds time-base pulse (prescaled by PRESCALE)
//   set_min, set_hour     single-cycle set pulses
//   hour_tens/ones, min_tens/ones, sec_tens/ones   BCD digits
//   pm                    afternoon flag (12-hour build only)
//   day_pulse             one-cycle pulse on midnight rollover
module time_of_day_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set_min,
  input  logic       set_hour,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       day_pulse
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

`ifdef FORMAT_12H_EN
  localparam logic [1:0] HT_RST = 2'd1;
  localparam logic [3:0] HO_RST = 4'd2;
`else
  localparam logic [1:0] HT_RST = 2'd0;
  localparam logic [3:0] HO_RST = 4'd0;
`endif

  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    hour_tens_nxt;
  logic [3:0]    hour_ones_nxt;
  logic [2:0]    min_tens_nxt;
  logic [3:0]    min_ones_nxt;
  logic [2:0]    sec_tens_nxt;
  logic [3:0]    sec_ones_nxt;
  logic          day_nxt;
  logic [7:0]    sec_r;
  logic [7:0]    min_r;
  logic [6:0]    hr_r;

  // Modulo-60 BCD increment: {carry, tens, ones}
  function automatic logic [7:0] inc_60(input logic [2:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o == 4'd9) begin
      if (t == 3'd5) r = {1'b1, 3'd0, 4'd0};
      else           r = {1'b0, 3'(t + 3'd1), 4'd0};
    end else begin
      r = {1'b0, t, 4'(o + 4'd1)};
    end
    return r;
  endfunction

  // Hour BCD increment: {flag, tens, ones}.
  // 24-hour: flag marks the 23 -> 00 wrap. 12-hour: flag marks 11 -> 12 (pm toggle).
  function automatic logic [6:0] hour_inc(input logic [1:0] t, input logic [3:0] o);
    logic [6:0] r;
`ifdef FORMAT_12H_EN
    if (t == 2'd1 && o == 4'd2)      r = {1'b0, 2'd0, 4'd1};
    else if (t == 2'd1 && o == 4'd1) r = {1'b1, 2'd1, 4'd2};
    else if (o == 4'd9)              r = {1'b0, 2'd1, 4'd0};
    else                             r = {1'b0, t, 4'(o + 4'd1)};
`else
    if (t == 2'd2 && o == 4'd3)      r = {1'b1, 2'd0, 4'd0};
    else if (o == 4'd9)              r = {1'b0, 2'(t + 2'd1), 4'd0};
    else                             r = {1'b0, t, 4'(o + 4'd1)};
`endif
    return r;
  endfunction

`ifdef FORMAT_12H_EN
  logic pm_q, pm_nxt;
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign sec_r = inc_60(sec_tens, sec_ones);
  assign min_r = inc_60(min_tens, min_ones);
  assign hr_r  = hour_inc(hour_tens, hour_ones);

  // Next-state: set_min overrides tick; set_hour blocks the minute-to-hour carry
  always_comb begin
    presc_nxt     = presc;
    hour_tens_nxt = hour_tens;
    hour_ones_nxt = hour_ones;
    min_tens_nxt  = min_tens;
    min_ones_nxt  = min_ones;
    sec_tens_nxt  = sec_tens;
    sec_ones_nxt  = sec_ones;
    day_nxt       = 1'b0;
`ifdef FORMAT_12H_EN
    pm_nxt        = pm_q;
`endif

    if (set_min) begin
      presc_nxt    = '0;
      sec_tens_nxt = 3'd0;
      sec_ones_nxt = 4'd0;
      {min_tens_nxt, min_ones_nxt} = min_r[6:0];
    end else if (tick) begin
      if (presc == PRE_LAST) begin
        presc_nxt = '0;
        {sec_tens_nxt, sec_ones_nxt} = sec_r[6:0];
        if (sec_r[7]) begin
          {min_tens_nxt, min_ones_nxt} = min_r[6:0];
          if (min_r[7] && !set_hour) begin
            {hour_tens_nxt, hour_ones_nxt} = hr_r[5:0];
`ifdef FORMAT_12H_EN
            if (hr_r[6]) begin
              pm_nxt  = ~pm_q;
              day_nxt = pm_q;
            end
`else
            day_nxt = hr_r[6];
`endif
          end
        end
      end else begin
        presc_nxt = PW'(presc + PW'(1));
      end
    end

    if (set_hour) begin
      {hour_tens_nxt, hour_ones_nxt} = hr_r[5:0];
`ifdef FORMAT_12H_EN
      if (hr_r[6]) pm_nxt = ~pm_q;
`endif
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      hour_tens <= HT_RST;
      hour_ones <= HO_RST;
      min_tens  <= 3'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 3'd0;
      sec_ones  <= 4'd0;
      day_pulse <= 1'b0;
`ifdef FORMAT_12H_EN
      pm_q      <= 1'b0;
`endif
    end else begin
      presc     <= presc_nxt;
      hour_tens <= hour_tens_nxt;
      hour_ones <= hour_ones_nxt;
      min_tens  <= min_tens_nxt;
      min_ones  <= min_ones_nxt;
      sec_tens  <= sec_tens_nxt;
      sec_ones  <= sec_ones_nxt;
      day_pulse <= day_nxt;
`ifdef FORMAT_12H_EN
      pm_q      <= pm_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Testbench for time_of_day_counter: two instances (PRESCALE = 1 and 4)
// share clock, reset and pulse inputs. Times are compared as packed
// BCD hhmmss values.
module tb_time_of_day_counter;

  logic clk, rst_n, tick, set_min, set_hour;

  logic [1:0] a_ht, b_ht;
  logic [3:0] a_ho, b_ho, a_mo, b_mo, a_so, b_so;
  logic [2:0] a_mt, b_mt, a_st, b_st;
  logic       a_pm, b_pm, a_day, b_day;
  logic [23:0] a_time, b_time;

  assign a_time = {2'b0, a_ht, a_ho, 1'b0, a_mt, a_mo, 1'b0, a_st, a_so};
  assign b_time = {2'b0, b_ht, b_ho, 1'b0, b_mt, b_mo, 1'b0, b_st, b_so};

  time_of_day_counter #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_min(set_min), .set_hour(set_hour),
    .hour_tens(a_ht), .hour_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .pm(a_pm), .day_pulse(a_day)
  );

  time_of_day_counter #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_min(set_min), .set_hour(set_hour),
    .hour_tens(b_ht), .hour_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .pm(b_pm), .day_pulse(b_day)
  );

`ifdef FORMAT_12H_EN
  localparam logic [23:0] HOME = 24'h120000;
`else
  localparam logic [23:0] HOME = 24'h000000;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic        t;
    logic        m;
    logic        h;
    logic [23:0] exp_time;
    logic        exp_day;
  } vec_t;

  vec_t vecs [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // One clock cycle with the given pulses; sampled 1 time unit after the edge
  task automatic cyc(input logic t, input logic m, input logic h);
    @(negedge clk);
    tick = t; set_min = m; set_hour = h;
    @(posedge clk);
    #1;
    tick = 1'b0; set_min = 1'b0; set_hour = 1'b0;
  endtask

  task automatic rep(input int n, input logic t, input logic m, input logic h);
    for (int i = 0; i < n; i++) cyc(t, m, h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic day_seen;

    vecs[0] = '{t:1, m:0, h:0, exp_time:24'h235959, exp_day:0};
    vecs[1] = '{t:1, m:0, h:0, exp_time:24'h000000, exp_day:1};
    vecs[2] = '{t:0, m:0, h:0, exp_time:24'h000000, exp_day:0};
    vecs[3] = '{t:0, m:0, h:1, exp_time:24'h010000, exp_day:0};
    vecs[4] = '{t:1, m:1, h:0, exp_time:24'h010100, exp_day:0};
    vecs[5] = '{t:1, m:0, h:0, exp_time:24'h010101, exp_day:0};
    vecs[6] = '{t:1, m:0, h:1, exp_time:24'h020102, exp_day:0};
    vecs[7] = '{t:0, m:1, h:1, exp_time:24'h030200, exp_day:0};
    vecs[8] = '{t:1, m:1, h:1, exp_time:24'h040300, exp_day:0};

    tick = 1'b0; set_min = 1'b0; set_hour = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_time", a_time, HOME);
    chk1("reset_pm", a_pm, 1'b0);
    chk1("reset_day", a_day, 1'b0);
    rst_n = 1'b1;

    // Prescaler 4: 7 ticks -> 1 second, set_min clears prescaler, 4 ticks -> +1 s
    do_reset();
    rep(7, 1, 0, 0);
    chk("p4_7ticks", b_time, HOME | 24'h000001);
    cyc(0, 1, 0);
    chk("p4_set_min", b_time, HOME | 24'h000100);
    rep(3, 1, 0, 0);
    chk("p4_3ticks", b_time, HOME | 24'h000100);
    cyc(1, 0, 0);
    chk("p4_4th_tick", b_time, HOME | 24'h000101);

`ifndef FORMAT_12H_EN
    // 60 ticks at PRESCALE 1 -> 00:01:00, no day pulse
    do_reset();
    day_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1, 0, 0);
      if (a_day) day_seen = 1'b1;
    end
    chk("sixty_ticks", a_time, 24'h000100);
    chk1("sixty_no_day", day_seen, 1'b0);

    // Preload 23:59:58, then table-driven vectors
    do_reset();
    rep(23, 0, 0, 1);
    chk("preload_hours", a_time, 24'h230000);
    rep(59, 0, 1, 0);
    rep(58, 1, 0, 0);
    chk("preload_full", a_time, 24'h235958);
    for (int i = 0; i < 9; i++) begin
      cyc(vecs[i].t, vecs[i].m, vecs[i].h);
      chk($sformatf("vec%0d_time", i), a_time, vecs[i].exp_time);
      chk1($sformatf("vec%0d_day", i), a_day, vecs[i].exp_day);
    end

    // 00:59:30 + set_min & tick -> 00:00:00; 24 set_hour -> 00, no day pulse
    do_reset();
    rep(59, 0, 1, 0);
    rep(30, 1, 0, 0);
    chk("pre_wrap_min", a_time, 24'h005930);
    cyc(1, 1, 0);
    chk("set_min_wrap", a_time, 24'h000000);
    day_seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 1);
      if (a_day) day_seen = 1'b1;
    end
    chk("hour_wrap24", a_time, 24'h000000);
    chk1("hour_wrap_no_day", day_seen, 1'b0);

    // set_hour drops the tick's minute-to-hour carry
    rep(59, 0, 1, 0);
    rep(59, 1, 0, 0);
    chk("pre_carry", a_time, 24'h005959);
    cyc(1, 0, 1);
    chk("carry_dropped", a_time, 24'h010000);

    // Asynchronous reset mid-count at 13:27:45
    do_reset();
    rep(13, 0, 0, 1);
    rep(27, 0, 1, 0);
    rep(45, 1, 0, 0);
    chk("pre_async", a_time, 24'h132745);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_time", a_time, 24'h000000);
    chk1("async_reset_day", a_day, 1'b0);
    rst_n = 1'b1;
`else
    // 12-hour: set_hour steps 12 -> 11 -> 12 with pm toggling, no day pulse
    do_reset();
    day_seen = 1'b0;
    rep(11, 0, 0, 1);
    chk("h12_eleven", a_time, 24'h110000);
    cyc(0, 0, 1);
    if (a_day) day_seen = 1'b1;
    chk("h12_set12", a_time, 24'h120000);
    chk1("h12_set12_pm", a_pm, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 1);
      if (a_day) day_seen = 1'b1;
    end
    chk("h12_set24", a_time, 24'h120000);
    chk1("h12_set24_pm", a_pm, 1'b0);
    chk1("h12_set_no_day", day_seen, 1'b0);

    // 11:59:59 am -> 12:00:00 pm (no day), 11:59:59 pm -> 12:00:00 am (day)
    rep(11, 0, 0, 1);
    rep(59, 0, 1, 0);
    rep(59, 1, 0, 0);
    chk("h12_am_1159", a_time, 24'h115959);
    cyc(1, 0, 0);
    chk("h12_noon", a_time, 24'h120000);
    chk1("h12_noon_pm", a_pm, 1'b1);
    chk1("h12_noon_day", a_day, 1'b0);
    rep(11, 0, 0, 1);
    rep(59, 0, 1, 0);
    rep(59, 1, 0, 0);
    cyc(1, 0, 0);
    chk("h12_midnight", a_time, 24'h120000);
    chk1("h12_midnight_pm", a_pm, 1'b0);
    chk1("h12_midnight_day", a_day, 1'b1);
    cyc(0, 0, 0);
    chk1("h12_day_one_cycle", a_day, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Time-of-day counter for the digital clock: consumes the single-cycle pulses produced by the pulse-generator stage (seconds tick, minute-set and hour-set buttons) and maintains hours, minutes and seconds as registered BCD digits for the display stage. Sits directly downstream of the pulse generators and upstream of the display multiplexer. Emits a one-cycle day-rollover pulse.

## Interface
- PRESCALE, default 1: number of tick pulses per one-second advance (≥1).
- rst_n  input  1  asynchronous reset, active low
- clk  input  1  system clock
- tick  input  1  seconds time-base pulse; each high cycle counts once
- set_min  input  1  minute-set pulse; each high cycle counts once
- set_hour  input  1  hour-set pulse; each high cycle counts once
- hour_tens  output  2  hours tens digit (BCD)
- hour_ones  output  4  hours ones digit (BCD)
- min_tens  output  3  minutes tens digit (BCD)
- min_ones  output  4  minutes ones digit (BCD)
- sec_tens  output  3  seconds tens digit (BCD)
- sec_ones  output  4  seconds ones digit (BCD)
- pm  output  1  afternoon flag (12-hour build only, else constant 0)
- day_pulse  output  1  one-cycle pulse on midnight rollover

## Operation
- One clock; reset is asynchronous and active-low (`rst_n`); all state on `clk`.
- Reset: all digits 0, prescaler 0, day_pulse 0, pm 0 (12-hour build: hours read 12, see Configuration).
- Prescaler counts 0..PRESCALE-1 on tick. The second advances on a tick with prescaler = PRESCALE-1, and the prescaler then returns to 0. Width is clog2(PRESCALE), minimum 1 bit.
- Second advance: BCD increment; 59 → 00 with carry to minutes. Minutes 59 → 00 with carry to hours. Hours 23 → 00 with carry to day_pulse.
- 23:59:59 + advance → 00:00:00, day_pulse = 1 for exactly that one cycle.
- set_min: minutes +1, wrapping 59 → 00 with no carry to hours. Seconds and prescaler clear to 0. A tick in the same cycle is ignored.
- set_hour: hours +1, wrapping 23 → 00. No day_pulse, minutes and seconds unchanged. A tick in the same cycle is still processed, but its minute-to-hour carry is dropped.
- set_min and set_hour together: both apply independently, with no carries.
- Each digit only ever holds legal BCD values. No state outside the legal ranges is reachable.

## Timing
- All outputs are registered. A pulse sampled high at edge N is reflected on the outputs after edge N; there is no combinational input-to-output path.
- day_pulse is high in the same cycle the outputs first show 00:00:00 (or 12:00:00 am).
- Reset assertion takes effect immediately, mid-count, and clears the prescaler. The first tick after release counts as prescaler step 0.
- Consecutive high cycles on any input count as consecutive events.

## Configuration
- FORMAT_12H_EN defined: 12-hour counting.
  - Hours sequence 12, 01, …, 11.
  - 11:59:59 + advance → 12:00:00 with pm toggled.
  - day_pulse fires only on the 11:59:59 pm → 12:00:00 am transition.
  - set_hour steps 11 → 12 and toggles pm on that step.
  - Reset value is 12:00:00 am (hour_tens = 1, hour_ones = 2, pm = 0).
- FORMAT_12H_EN not defined: 24-hour counting as above, pm tied 0.

## Test plan
- Reset, PRESCALE = 1, 60 single-cycle ticks → 00:01:00, day_pulse never high.
- Preload to 23:59:58 via set pulses and ticks, then 2 ticks → 23:59:59, then 00:00:00 with day_pulse high for exactly 1 cycle.
- PRESCALE = 4, 7 ticks → sec_ones = 1. Then set_min → 00:01:00. Then 4 more ticks → 00:01:01.
- 00:59:30, then set_min and tick in the same cycle → 00:00:00. Then 24 set_hour pulses → hours 00, no day_pulse.
- rst_n pulled low mid-count at 13:27:45 → all outputs 0 immediately, asynchronously, before the next clk edge.
- FORMAT_12H_EN build: reset → 12:00:00 pm = 0. 12 set_hour pulses → 12 with pm = 1. 12 more → 12 with pm = 0, no day_pulse.
